// File: rtl/f8_fetch_pkg.sv
// Shared types for the f8 instruction fetch path.
package f8_fetch_pkg;
    localparam int FETCH_BYTES = 3;

    typedef logic [7:0]  byte_t;
    typedef logic [15:0] addr_t;
    typedef logic [1:0]  len_t;

    // One outstanding memory read: valid flag plus the address it was issued for.
    typedef struct packed {
        logic  vld;
        addr_t addr;
    } ireq_t;
endpackage

// File: rtl/f8_fetch_byte_queue.sv
// Byte shift queue: pop up to 3 from the head, append 3 behind the survivors, flush.
module f8_fetch_byte_queue
    import f8_fetch_pkg::*;
#(
    parameter int QDEPTH = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        push,
    input  logic [23:0] push_data,
    input  logic        pop,
    input  len_t        pop_len,
    output logic [23:0] head,
    output logic [3:0]  count
);
    logic [QDEPTH-1:0][7:0] q, q_nxt;
    logic [3:0]             cnt_nxt;
    logic [3:0]             base;
    len_t                   pop_amt;

    assign pop_amt = pop ? pop_len : 2'd0;
    assign base    = count - {2'b00, pop_amt};

    // Zeros shift in from the top, so bytes beyond count always read as 0.
    always_comb begin
        q_nxt   = q >> (8 * pop_amt);
        cnt_nxt = base + (push ? 4'd3 : 4'd0);
        for (int i = 0; i < QDEPTH; i++)
            for (int k = 0; k < FETCH_BYTES; k++)
                if (push && i >= k && base == 4'(i - k))
                    q_nxt[i] = push_data[8*k +: 8];
        if (flush) begin
            q_nxt   = '0;
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q     <= '0;
            count <= '0;
        end else begin
            q     <= q_nxt;
            count <= cnt_nxt;
        end
    end

    assign head = q[2:0];
endmodule

// File: rtl/f8_ifetch.sv
// f8 instruction fetch: PC tracking, prefetch issue, response capture and redirect.
module f8_ifetch
    import f8_fetch_pkg::*;
#(
    parameter addr_t RESET_PC = 16'h4000,
    parameter int    QDEPTH   = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] iread_addr,
    input  logic [23:0] iread_data,
    input  logic        iread_valid,
    output logic [23:0] insn_data,
    output logic [1:0]  insn_avail,
    output logic [15:0] insn_pc,
    input  logic        consume,
    input  logic [1:0]  consume_len,
    input  logic        redirect,
    input  logic [15:0] redirect_addr
);
    addr_t      pc, fetch_addr;
    ireq_t      req;
    logic [3:0] count;
    logic       len_ok, pop, push, drop, space_ok, issue;

    assign insn_avail = (count >= 4'd3) ? 2'd3 : count[1:0];
    assign insn_pc    = pc;
    assign iread_addr = fetch_addr;

    // An illegal length (0 or more than available) is dropped, not partially applied.
    assign len_ok = consume && consume_len != 2'd0 && consume_len <= insn_avail;
    assign pop    = len_ok && !redirect;
    assign push   = req.vld && iread_valid && !redirect;
    assign drop   = req.vld && !iread_valid;

    // Reserve room for the pending response before issuing another 3 bytes.
    assign space_ok = (QDEPTH - int'(count) - (req.vld ? FETCH_BYTES : 0)
                       + (len_ok ? int'(consume_len) : 0)) >= FETCH_BYTES;
    assign issue    = !redirect && !drop && space_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC;
            req        <= '0;
        end else if (redirect) begin
            pc         <= redirect_addr;
            fetch_addr <= redirect_addr;
            req.vld    <= 1'b0;
        end else begin
            if (pop)
                pc <= pc + {14'b0, consume_len};
            if (drop)
                fetch_addr <= req.addr;
            else if (issue)
                fetch_addr <= fetch_addr + 16'd3;
            req.vld <= issue;
            if (issue)
                req.addr <= fetch_addr;
        end
    end

    f8_fetch_byte_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect),
        .push      (push),
        .push_data (iread_data),
        .pop       (pop),
        .pop_len   (consume_len),
        .head      (insn_data),
        .count     (count)
    );
endmodule

// File: tb/tb_f8_ifetch.sv
// Directed bench for f8_ifetch with a one-cycle-latency program memory model.
module tb_f8_ifetch;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] iread_addr;
    logic [23:0] iread_data = '0;
    logic        iread_valid = 1'b0;
    logic [23:0] insn_data;
    logic [1:0]  insn_avail;
    logic [15:0] insn_pc;
    logic        consume, redirect, drop;
    logic [1:0]  consume_len;
    logic [15:0] redirect_addr;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_pc;

    always #5 clk = ~clk;

    f8_ifetch #(.RESET_PC(16'h4000), .QDEPTH(6)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .iread_addr    (iread_addr),
        .iread_data    (iread_data),
        .iread_valid   (iread_valid),
        .insn_data     (insn_data),
        .insn_avail    (insn_avail),
        .insn_pc       (insn_pc),
        .consume       (consume),
        .consume_len   (consume_len),
        .redirect      (redirect),
        .redirect_addr (redirect_addr)
    );

    // Memory image: 0x4000.. = 01 02 03 ..., perturbed by the page so pages differ.
    function automatic logic [7:0] mb(input logic [15:0] a);
        logic [15:0] d;
        d = a - 16'h3FFF;
        return d[7:0] ^ (a[15:8] - 8'h40);
    endfunction

    function automatic logic [23:0] mem3(input logic [15:0] a);
        return {mb(a + 16'd2), mb(a + 16'd1), mb(a)};
    endfunction

    always @(posedge clk) begin
        iread_data  <= mem3(iread_addr);
        iread_valid <= !drop;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [15:0] a);
        consume       = 1'b0;
        redirect      = 1'b1;
        redirect_addr = a;
        step();
        redirect      = 1'b0;
    endtask

    logic [1:0]  lens [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
    logic [15:0] pcs  [4] = '{16'h4001, 16'h4003, 16'h4006, 16'h4007};

    initial begin
        reset_n = 1'b0; consume = 1'b0; consume_len = 2'd0;
        redirect = 1'b0; redirect_addr = '0; drop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_iread_addr", 32'(iread_addr), 32'h4000);
        chk("rst_avail", 32'(insn_avail), 32'd0);
        chk("rst_data", 32'(insn_data), 32'h0);
        chk("rst_pc", 32'(insn_pc), 32'h4000);

        // Startup: cycle 0 is the cycle after release.
        reset_n = 1'b1;
        chk("c0_iread_addr", 32'(iread_addr), 32'h4000);
        step();
        chk("c1_iread_addr", 32'(iread_addr), 32'h4003);
        chk("c1_avail", 32'(insn_avail), 32'd0);
        step();
        chk("c2_avail", 32'(insn_avail), 32'd3);
        chk("c2_data", 32'(insn_data), 32'h030201);
        chk("c2_pc", 32'(insn_pc), 32'h4000);

        // No consume: queue fills, fetch stalls at 4006.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fill_iread_addr", 32'(iread_addr), 32'h4006);
            chk("fill_data", 32'(insn_data), 32'h030201);
            chk("fill_avail", 32'(insn_avail), 32'd3);
        end

        // Sustained 3 bytes per cycle.
        exp_pc = 16'h4000;
        consume = 1'b1; consume_len = 2'd3;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_pc = exp_pc + 16'd3;
            chk("strm_pc", 32'(insn_pc), 32'(exp_pc));
            chk("strm_avail", 32'(insn_avail), 32'd3);
            chk("strm_data", 32'(insn_data), 32'(mem3(exp_pc)));
        end
        chk("strm_final_pc", 32'(insn_pc), 32'h4012);

        // Redirect while a response is in flight.
        do_redirect(16'h4100);
        chk("r1_avail", 32'(insn_avail), 32'd0);
        chk("r1_data", 32'(insn_data), 32'h0);
        chk("r1_pc", 32'(insn_pc), 32'h4100);
        chk("r1_iread_addr", 32'(iread_addr), 32'h4100);
        step();
        chk("r2_avail", 32'(insn_avail), 32'd0);
        chk("r2_iread_addr", 32'(iread_addr), 32'h4103);
        step();
        chk("r3_avail", 32'(insn_avail), 32'd3);
        chk("r3_pc", 32'(insn_pc), 32'h4100);
        chk("r3_data", 32'(insn_data), 32'h020300);

        // Dropped response: address is reissued, stream stays in order.
        do_redirect(16'h4200);
        chk("d1_iread_addr", 32'(iread_addr), 32'h4200);
        drop = 1'b1;
        step();
        drop = 1'b0;
        chk("d2_iread_addr", 32'(iread_addr), 32'h4203);
        chk("d2_avail", 32'(insn_avail), 32'd0);
        step();
        chk("d3_iread_addr", 32'(iread_addr), 32'h4200);
        chk("d3_avail", 32'(insn_avail), 32'd0);
        step();
        chk("d4_avail", 32'(insn_avail), 32'd0);
        chk("d4_iread_addr", 32'(iread_addr), 32'h4203);
        step();
        chk("d5_avail", 32'(insn_avail), 32'd3);
        chk("d5_pc", 32'(insn_pc), 32'h4200);
        chk("d5_data", 32'(insn_data), 32'(mem3(16'h4200)));
        consume = 1'b1; consume_len = 2'd3;
        step();
        consume = 1'b0;
        chk("d6_pc", 32'(insn_pc), 32'h4203);
        chk("d6_data", 32'(insn_data), 32'(mem3(16'h4203)));
        chk("d6_avail", 32'(insn_avail), 32'd3);

        // Variable-length consumption from 4000.
        do_redirect(16'h4000);
        step();
        step();
        chk("v0_avail", 32'(insn_avail), 32'd3);
        chk("v0_pc", 32'(insn_pc), 32'h4000);
        chk("v0_data", 32'(insn_data), 32'h030201);
        for (int i = 0; i < 4; i++) begin
            chk("v_len_legal", 32'(insn_avail >= lens[i]), 32'd1);
            consume = 1'b1; consume_len = lens[i];
            step();
            chk("v_pc", 32'(insn_pc), 32'(pcs[i]));
            chk("v_data", 32'(insn_data), 32'(mem3(pcs[i])));
            chk("v_avail", 32'(insn_avail), 32'd3);
        end
        consume = 1'b0;

        // Address wrap at the top of memory.
        do_redirect(16'hFFFE);
        chk("w1_iread_addr", 32'(iread_addr), 32'hFFFE);
        chk("w1_pc", 32'(insn_pc), 32'hFFFE);
        step();
        chk("w2_iread_addr", 32'(iread_addr), 32'h0001);
        step();
        chk("w3_avail", 32'(insn_avail), 32'd3);
        chk("w3_pc", 32'(insn_pc), 32'hFFFE);
        chk("w3_data", 32'(insn_data), 32'hC1BF40);
        consume = 1'b1; consume_len = 2'd3;
        step();
        consume = 1'b0;
        chk("w4_pc", 32'(insn_pc), 32'h0001);
        chk("w4_data", 32'(insn_data), 32'hC4C3C2);
        chk("w4_avail", 32'(insn_avail), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of stimulus, expected finish before 100000");
        $fatal(1);
    end
endmodule

// File: doc/f8_ifetch.md
Name: f8_ifetch

Overview:
- Instruction fetch/prefetch unit for the f8 core.
- Acts as initiator on the instruction-read port of program memory: drives iread_addr and consumes iread_data/iread_valid.
- Buffers returned bytes in a small byte queue and presents up to 3 bytes at the current PC to the decoder.
- Handles variable-length consumption (1–3 bytes) and branch redirects.

Parameters:
- RESET_PC, 16'h4000: PC and first fetch address after reset.
- QDEPTH, 6: byte queue depth. Legal range is 6..8.

Ports:
- clk  input  1: clock, rising edge.
- reset_n  input  1: reset, asynchronous, active-low.
- iread_addr  output  16: program memory fetch address.
- iread_data  input  24: 3 bytes from addr, addr+1, addr+2 on [7:0], [15:8], [23:16]; valid one cycle after the address is presented.
- iread_valid  input  1: qualifies iread_data in the response cycle.
- insn_data  output  24: queue bytes 0..2, byte 0 on [7:0]; bytes beyond count read as 0.
- insn_avail  output  2: min(count, 3).
- insn_pc  output  16: address of queue byte 0.
- consume  input  1: decoder removes consume_len bytes this cycle.
- consume_len  input  2: 1..3.
- redirect  input  1: flush the queue and restart fetch.
- redirect_addr  input  16: new PC.

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low.
- Registered state: pc, fetch_addr, count (0..QDEPTH), req_q (response pending), req_addr_q (address of the pending request), byte queue.
- Reset values: pc = fetch_addr = RESET_PC; count = 0; req_q = 0; queue bytes = 0. Resulting outputs: iread_addr = RESET_PC, insn_avail = 0, insn_data = 0, insn_pc = RESET_PC.
- Output timing:
  - iread_addr = fetch_addr, driven directly from the register.
  - insn_* are combinational from registers only.
- Memory timing: memory samples the address at the edge ending cycle N; data is visible in cycle N+1; the unit captures it at the edge ending N+1.
- Issue rule in cycle N: issue = !redirect && !(req_q && !iread_valid) && (QDEPTH - count - 3*req_q + (consume ? consume_len : 0)) >= 3.
- On issue:
  - req_q <= 1; req_addr_q <= fetch_addr; fetch_addr <= fetch_addr + 3.
  - At most one request is outstanding per cycle. Back-to-back issue is allowed.
- Response handling (req_q = 1):
  - iread_valid = 1: append 3 bytes at queue position count - consumed.
  - iread_valid = 0: discard; fetch_addr <= req_addr_q; no issue that cycle, so the address is reissued next cycle.
- Consume:
  - Shift the queue down by consume_len and add consume_len to pc.
  - Consume and append in the same cycle are both applied: count_next = count - len + 3.
  - consume_len = 0 or consume_len > insn_avail is a protocol error: the consume is ignored and the bench asserts.
- Redirect:
  - Highest priority; overrides consume and response.
  - At the edge: count <= 0; pc <= fetch_addr <= redirect_addr; req_q <= 0, so any in-flight response is discarded.
  - No issue in the redirect cycle.
  - Redirect in cycle R: first issue in R+1, data appended at the end of R+2, insn_avail = 3 in R+3.
- Arithmetic: all addresses are 16-bit and wrap modulo 2^16. Memory handles the +1/+2 wrap within a fetch.
- Startup latency: first request in cycle 0 after reset release; insn_avail = 3 in cycle 2.
- Throughput: sustained 3 bytes/cycle with QDEPTH = 6 when the decoder consumes 3 per cycle.
- Invariants:
  - count never exceeds QDEPTH.
  - Bytes are delivered in strict address order.
  - fetch_addr == pc + count + 3*req_q (mod 2^16) when no response is dropped.

Decomposition:
- Package f8_fetch_pkg:
  - FETCH_BYTES = 3
  - typedef logic [7:0] byte_t
  - typedef logic [15:0] addr_t
  - typedef logic [1:0] len_t
- Sub-module f8_fetch_byte_queue: byte shift queue with push3 / pop(len) / flush and count output.
- Top level f8_ifetch holds the PC, issue logic and response tracking.

Test Plan:
- Reset release, memory at 0x4000 = 01 02 03 04 05 06 … -> iread_addr 4000 in cycle 0, 4003 in cycle 1; cycle 2: insn_avail = 3, insn_data = 24'h030201, insn_pc = 4000.
- No consume -> queue fills to 6; iread_addr holds 4006 and no further appends; insn_data stays 24'h030201.
- Consume len 3 every cycle from cycle 2 -> insn_avail stays 3; insn_pc advances 4000, 4003, 4006, …; no bubbles.
- Consume lengths 1, 2, 3, 1 -> insn_pc 4000, 4001, 4003, 4006, 4007; insn_data matches memory at each PC.
- Redirect to 0x4100 with a request in flight -> stale bytes never appear; insn_avail = 0 in R+1 and R+2; insn_pc = 4100; R+3 shows data from 4100.
- iread_valid forced low on one response -> bytes not appended; iread_addr returns to the dropped address; byte stream remains in order.
- Redirect to 0xFFFE -> bytes from FFFE, FFFF, 0000; fetch_addr wraps to 0x0001; insn_pc wraps correctly after consume.
